// File: rtl/mips_cpu_state_ctrl_if.sv
// rtl/mips_cpu_state_ctrl_if.sv - Avalon-style bus handshake between the sequencer and memory
//
// Signals:
//   waitrequest_i  memory -> sequencer, holds the current read/write while high
//   mem_read_o     sequencer -> memory, read strobe
//   mem_write_o    sequencer -> memory, write strobe
// Modports:
//   master  the sequencer side (drives the strobes)
//   slave   the memory side (drives waitrequest)
interface mips_cpu_state_ctrl_if;
    logic waitrequest_i;
    logic mem_read_o;
    logic mem_write_o;

    modport master (
        input  waitrequest_i,
        output mem_read_o,
        output mem_write_o
    );

    modport slave (
        output waitrequest_i,
        input  mem_read_o,
        input  mem_write_o
    );
endinterface

// File: rtl/mips_cpu_state_ctrl.sv
// rtl/mips_cpu_state_ctrl.sv - multicycle INIT/FETCH/EXEC1/EXEC2/STALL/HALTED sequencer for the MIPS core
//
// Optional feature macro: STATE_CTRL_PERF_EN (builds the cycle/retired counters;
// when undefined cycles_o and retired_o are tied to 0 and no counter flops exist).
//
// Ports:
//   clk            rising-edge clock
//   reset_i        asynchronous active-high reset
//   bus            bus handshake (master modport): waitrequest_i, mem_read_o, mem_write_o
//   mem_access_i   decoded instruction is a load/store
//   mem_write_i    decoded instruction is a store
//   needs_exec2_i  instruction needs the EXEC2 writeback cycle
//   writes_reg_i   instruction writes a GPR at the end of EXEC1
//   muldiv_busy_i  multiply/divide unit still computing
//   halt_req_i     PC target is zero, sampled at instruction end
//   state_o        encoded state (INIT=0 FETCH=1 EXEC1=2 EXEC2=3 STALL=4 HALTED=5)
//   ir_wen_o, pc_wen_o, regfile_wen_o   datapath write enables
//   active_o       CPU running
//   fault_o        stall limit exceeded or illegal state, sticky until reset
//   cycles_o, retired_o  performance counters
module mips_cpu_state_ctrl #(
    parameter int STALL_LIMIT = 64
) (
    input  logic                         clk,
    input  logic                         reset_i,
    mips_cpu_state_ctrl_if.master        bus,
    input  logic                         mem_access_i,
    input  logic                         mem_write_i,
    input  logic                         needs_exec2_i,
    input  logic                         writes_reg_i,
    input  logic                         muldiv_busy_i,
    input  logic                         halt_req_i,
    output logic [2:0]                   state_o,
    output logic                         ir_wen_o,
    output logic                         pc_wen_o,
    output logic                         regfile_wen_o,
    output logic                         active_o,
    output logic                         fault_o,
    output logic [31:0]                  cycles_o,
    output logic [31:0]                  retired_o
);

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC1  = 3'd2;
    localparam logic [2:0] S_EXEC2  = 3'd3;
    localparam logic [2:0] S_STALL  = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    localparam int CW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [CW-1:0] STALL_LAST = CW'(STALL_LIMIT - 1);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic          exec1_first;
    logic          halt_pending;
    logic [CW-1:0] stall_cnt;
    logic          fault;

    logic ir_wen;
    logic pc_wen;
    logic rf_wen;
    logic mem_rd;
    logic mem_wr;
    logic exec1_exit;
    logic stall_timeout;

    // EXEC1 is held only while a bus access is outstanding.
    assign exec1_exit    = (state == S_EXEC1) && !(mem_access_i && bus.waitrequest_i);
    assign stall_timeout = (state == S_STALL) && muldiv_busy_i && (stall_cnt == STALL_LAST);

    always_comb begin
        state_next = state;
        ir_wen     = 1'b0;
        pc_wen     = 1'b0;
        rf_wen     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            S_INIT: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (!bus.waitrequest_i) begin
                    state_next = S_EXEC1;
                end
            end
            S_EXEC1: begin
                ir_wen = exec1_first;
                if (mem_access_i) begin
                    mem_wr = mem_write_i;
                    mem_rd = !mem_write_i;
                end
                if (exec1_exit) begin
                    pc_wen = 1'b1;
                    rf_wen = writes_reg_i && !needs_exec2_i;
                    if (needs_exec2_i) begin
                        state_next = S_EXEC2;
                    end else if (muldiv_busy_i) begin
                        state_next = S_STALL;
                    end else if (halt_req_i) begin
                        state_next = S_HALTED;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_EXEC2: begin
                rf_wen = 1'b1;
                if (muldiv_busy_i) begin
                    state_next = S_STALL;
                end else if (halt_pending || halt_req_i) begin
                    state_next = S_HALTED;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_STALL: begin
                if (!muldiv_busy_i) begin
                    state_next = halt_pending ? S_HALTED : S_FETCH;
                end else if (stall_timeout) begin
                    state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state        <= S_INIT;
            exec1_first  <= 1'b1;
            halt_pending <= 1'b0;
            stall_cnt    <= '0;
            fault        <= 1'b0;
        end else begin
            state <= state_next;

            if (state == S_FETCH && !bus.waitrequest_i) begin
                exec1_first <= 1'b1;
            end else if (state == S_EXEC1) begin
                exec1_first <= 1'b0;
            end

            // A halt seen while the instruction still has EXEC2/STALL work to do
            // is remembered so those states can finish before halting.
            if (exec1_exit && halt_req_i && (needs_exec2_i || muldiv_busy_i)) begin
                halt_pending <= 1'b1;
            end

            if (state == S_STALL && muldiv_busy_i && !stall_timeout) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end

            if (stall_timeout || (state > S_HALTED)) begin
                fault <= 1'b1;
            end
        end
    end

    // Gating on reset_i keeps every strobe low from the instant reset asserts.
    assign state_o         = state;
    assign ir_wen_o        = ir_wen && !reset_i;
    assign pc_wen_o        = pc_wen && !reset_i;
    assign regfile_wen_o   = rf_wen && !reset_i;
    assign bus.mem_read_o  = mem_rd && !reset_i;
    assign bus.mem_write_o = mem_wr && !reset_i;
    assign active_o        = reset_i || (state != S_HALTED);
    assign fault_o         = fault;

`ifdef STATE_CTRL_PERF_EN
    logic [31:0] cycles_q;
    logic [31:0] retired_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            cycles_q  <= '0;
            retired_q <= '0;
        end else if (state != S_HALTED) begin
            cycles_q <= cycles_q + 32'd1;
            if (pc_wen) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign cycles_o  = cycles_q;
    assign retired_o = retired_q;
`else
    assign cycles_o  = 32'd0;
    assign retired_o = 32'd0;
`endif

endmodule

// File: tb/tb_mips_cpu_state_ctrl.sv
// tb/tb_mips_cpu_state_ctrl.sv - scoreboard bench for mips_cpu_state_ctrl with a behavioural reference model
module tb_mips_cpu_state_ctrl;

    localparam int LIM = 8;

    logic        clk;
    logic        reset_i;
    logic        mem_access_i;
    logic        mem_write_i;
    logic        needs_exec2_i;
    logic        writes_reg_i;
    logic        muldiv_busy_i;
    logic        halt_req_i;
    logic [2:0]  state_o;
    logic        ir_wen_o;
    logic        pc_wen_o;
    logic        regfile_wen_o;
    logic        active_o;
    logic        fault_o;
    logic [31:0] cycles_o;
    logic [31:0] retired_o;

    mips_cpu_state_ctrl_if bus ();

    mips_cpu_state_ctrl #(.STALL_LIMIT(LIM)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .bus           (bus.master),
        .mem_access_i  (mem_access_i),
        .mem_write_i   (mem_write_i),
        .needs_exec2_i (needs_exec2_i),
        .writes_reg_i  (writes_reg_i),
        .muldiv_busy_i (muldiv_busy_i),
        .halt_req_i    (halt_req_i),
        .state_o       (state_o),
        .ir_wen_o      (ir_wen_o),
        .pc_wen_o      (pc_wen_o),
        .regfile_wen_o (regfile_wen_o),
        .active_o      (active_o),
        .fault_o       (fault_o),
        .cycles_o      (cycles_o),
        .retired_o     (retired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir;
        logic        pc;
        logic        rf;
        logic        rd;
        logic        wr;
        logic        act;
        logic        flt;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: phase of the current instruction, in the output encoding.
    int          m_phase;
    bit          m_ir_pending;
    bit          m_halt_later;
    int          m_busy_run;
    bit          m_fault;
    logic [31:0] m_cyc;
    logic [31:0] m_ret;

    task automatic model_reset();
        m_phase      = 0;
        m_ir_pending = 1'b1;
        m_halt_later = 1'b0;
        m_busy_run   = 0;
        m_fault      = 1'b0;
        m_cyc        = 32'd0;
        m_ret        = 32'd0;
    endtask

    task automatic predict(output exp_t e);
        bit done_exec1;
        e = '0;
        e.act = 1'b1;
        if (!reset_i) begin
            done_exec1 = !(mem_access_i && bus.waitrequest_i);
            e.st  = 3'(m_phase);
            e.flt = m_fault;
            e.act = (m_phase != 5);
`ifdef STATE_CTRL_PERF_EN
            e.cyc = m_cyc;
            e.ret = m_ret;
`endif
            if (m_phase == 1) e.rd = 1'b1;
            if (m_phase == 2) begin
                e.ir = m_ir_pending;
                e.rd = mem_access_i && !mem_write_i;
                e.wr = mem_access_i && mem_write_i;
                e.pc = done_exec1;
                e.rf = done_exec1 && writes_reg_i && !needs_exec2_i;
            end
            if (m_phase == 3) e.rf = 1'b1;
        end
    endtask

    task automatic advance(input exp_t e);
        int nxt;
        if (reset_i) begin
            model_reset();
        end else begin
            if (m_phase != 5) begin
                m_cyc = m_cyc + 32'd1;
                if (e.pc) m_ret = m_ret + 32'd1;
            end
            nxt = m_phase;
            if (m_phase == 0) nxt = 1;
            else if (m_phase == 1) begin
                if (!bus.waitrequest_i) begin
                    nxt = 2;
                    m_ir_pending = 1'b1;
                end
            end else if (m_phase == 2) begin
                m_ir_pending = 1'b0;
                if (e.pc) begin
                    nxt = needs_exec2_i ? 3 : muldiv_busy_i ? 4 : halt_req_i ? 5 : 1;
                    if (halt_req_i && (nxt == 3 || nxt == 4)) m_halt_later = 1'b1;
                end
            end else if (m_phase == 3) begin
                nxt = muldiv_busy_i ? 4 : (m_halt_later || halt_req_i) ? 5 : 1;
            end else if (m_phase == 4) begin
                if (!muldiv_busy_i) begin
                    nxt = m_halt_later ? 5 : 1;
                    m_busy_run = 0;
                end else if (m_busy_run + 1 >= LIM) begin
                    nxt = 5;
                    m_fault = 1'b1;
                    m_busy_run = 0;
                end else begin
                    m_busy_run = m_busy_run + 1;
                end
            end
            m_phase = nxt;
        end
    endtask

    // One clock of stimulus: inputs already set by the caller.
    task automatic step(input bit rst_mid, input bit rel_mid);
        exp_t e;
        if (rst_mid) begin
            #1 reset_i = 1'b1;
        end
        predict(e);
        sb.push_back(e);
        if (rel_mid) begin
            #2 reset_i = 1'b0;
        end
        @(posedge clk);
        advance(e);
        #1;
    endtask

    task automatic set_in(input bit w, input bit acc, input bit mw, input bit x2,
                          input bit wr, input bit busy, input bit halt);
        bus.waitrequest_i = w;
        mem_access_i      = acc;
        mem_write_i       = mw;
        needs_exec2_i     = x2;
        writes_reg_i      = wr;
        muldiv_busy_i     = busy;
        halt_req_i        = halt;
    endtask

    task automatic rand_in();
        set_in($urandom_range(9) < 3, $urandom_range(9) < 4, $urandom_range(1) == 1,
               $urandom_range(3) == 0, $urandom_range(1) == 1, $urandom_range(9) < 3,
               $urandom_range(19) == 0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        step(0, 0);
        step(0, 0);
        reset_i = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                chk("state",   32'(state_o),         32'(e.st));
                chk("ir_wen",  32'(ir_wen_o),        32'(e.ir));
                chk("pc_wen",  32'(pc_wen_o),        32'(e.pc));
                chk("rf_wen",  32'(regfile_wen_o),   32'(e.rf));
                chk("mem_rd",  32'(bus.mem_read_o),  32'(e.rd));
                chk("mem_wr",  32'(bus.mem_write_o), 32'(e.wr));
                chk("active",  32'(active_o),        32'(e.act));
                chk("fault",   32'(fault_o),         32'(e.flt));
                chk("cycles",  cycles_o,             e.cyc);
                chk("retired", retired_o,            e.ret);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        reset_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // ALU op: INIT, FETCH, single EXEC1 with ir/pc/regfile writes, then FETCH.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);
        set_in(0, 0, 0, 0, 1, 0, 0); step(0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0); step(0, 0);

        // Load held three cycles by waitrequest, then EXEC2 writeback.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 1, 1, 0, 0); step(0, 0);
        end
        set_in(0, 1, 0, 1, 1, 0, 0); step(0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);

        // Store without wait.
        set_in(0, 1, 1, 0, 1, 0, 0); step(0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);

        // Halt request while muldiv busy: STALL, then HALTED and absorbing.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);
        set_in(0, 0, 0, 0, 0, 1, 1); step(0, 0);
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 1, 1); step(0, 0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);
        for (int i = 0; i < 20; i++) begin
            rand_in(); step(0, 0);
        end

        // muldiv stuck busy: stall limit forces HALTED with fault.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);
        for (int i = 0; i < LIM + 4; i++) begin
            set_in(0, 0, 0, 0, 0, 1, 0); step(0, 0);
        end

        // Asynchronous reset in the middle of a stalled FETCH.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0); step(0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0); step(1, 0);
        set_in(1, 0, 0, 0, 0, 0, 0); step(0, 1);
        set_in(1, 0, 0, 0, 0, 0, 0); step(0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0); step(0, 0);

        // Random episodes, each from reset until a few cycles into HALTED.
        for (int ep = 0; ep < 40; ep++) begin
            int halted_for;
            halted_for = 0;
            do_reset();
            for (int c = 0; c < 120 && halted_for < 4; c++) begin
                rand_in();
                step(0, 0);
                if (m_phase == 5) halted_for++;
            end
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_state_ctrl.md
Name: mips_cpu_state_ctrl

Overview:
Multicycle sequencer for the MIPS CPU core.
- Drives the INIT/FETCH/EXEC1/EXEC2/STALL/HALTED state machine.
- Generates write enables for the instruction register, PC and register file, and the memory read/write strobes of the Avalon-style bus.
- Sits between the bus interface and the datapath; decode outputs of the instruction register feed its classification inputs.

Parameters:
- STALL_LIMIT, 64: maximum consecutive STALL cycles before the block forces HALTED and raises fault_o.

Ports:
- clk  in  1  clock, rising-edge.
- reset_i  in  1  asynchronous, active-high reset.
- waitrequest_i  in  1  bus stall; the current read/write is held while high.
- mem_access_i  in  1  decoded instruction is a load/store (valid while ir_wen_o high or state EXEC1).
- mem_write_i  in  1  decoded instruction is a store (qualifies mem_access_i).
- needs_exec2_i  in  1  instruction requires the EXEC2 writeback cycle (loads).
- writes_reg_i  in  1  instruction writes a GPR at the end of EXEC1 (ALU/link ops).
- muldiv_busy_i  in  1  multiply/divide unit still computing.
- halt_req_i  in  1  PC target is 0x00000000 (jump to zero), sampled at instruction end.
- state_o  out  3  encoded state: INIT=0, FETCH=1, EXEC1=2, EXEC2=3, STALL=4, HALTED=5.
- ir_wen_o  out  1  latch instruction into the IR.
- pc_wen_o  out  1  advance or update PC.
- regfile_wen_o  out  1  GPR write strobe.
- mem_read_o  out  1  bus read.
- mem_write_o  out  1  bus write.
- active_o  out  1  CPU running.
- fault_o  out  1  stall-limit exceeded (sticky until reset).
- cycles_o  out  32  performance counter (see Optional Feature).
- retired_o  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high):
  - state=INIT, exec1_first=1, halt_pending=0, stall_cnt=0, fault_o=0, counters=0.
  - While reset_i is high, all strobes are 0 and active_o=1.
- INIT: all strobes 0; goes to FETCH on the next cycle.
- FETCH: mem_read_o=1.
  - Stays while waitrequest_i=1.
  - Otherwise goes to EXEC1 and sets exec1_first=1.
- EXEC1: read data is valid in this cycle.
  - ir_wen_o=1 only while exec1_first=1; exec1_first clears after the first EXEC1 cycle.
  - If mem_access_i=1: mem_write_o=mem_write_i and mem_read_o=!mem_write_i. Stays in EXEC1 while waitrequest_i=1. No ir_wen_o re-assertion during the hold.
  - Exit cycle (no access, or waitrequest_i=0): pc_wen_o=1 exactly once; regfile_wen_o=writes_reg_i & !needs_exec2_i.
  - Next state, in priority order: EXEC2 if needs_exec2_i; else STALL if muldiv_busy_i; else HALTED if halt_req_i; else FETCH.
  - halt_req_i sampled at exit while going to EXEC2 or STALL sets halt_pending.
- EXEC2: regfile_wen_o=1 for one cycle. Then STALL if muldiv_busy_i, else HALTED if halt_pending|halt_req_i, else FETCH.
- STALL:
  - All strobes 0; stall_cnt increments each cycle.
  - When muldiv_busy_i=0, goes to HALTED if halt_pending, else FETCH; stall_cnt clears.
  - When stall_cnt reaches STALL_LIMIT-1 while busy: goes to HALTED and sets fault_o=1.
- HALTED: active_o=0 and all strobes 0. Absorbing until reset.
- halt_pending is cleared only by reset.
- Strobes are combinational decodes of registered state plus inputs; there is no extra output latency.
- Illegal state encodings (6, 7) go to HALTED and set fault_o.
- Reset mid-transaction aborts immediately; no strobe persists after reset assertion.

Optional Feature:
- STATE_CTRL_PERF_EN defined:
  - cycles_o increments every cycle while active_o=1.
  - retired_o increments on every pc_wen_o.
  - Both counters wrap from 0xFFFFFFFF to 0 and are frozen in HALTED.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- ALU op with writes_reg_i=1, waitrequest_i=0 -> INIT,FETCH,EXEC1 then FETCH; ir_wen_o, pc_wen_o and regfile_wen_o high in the single EXEC1 cycle; retired_o=1.
- Load with needs_exec2_i=1 and waitrequest_i=1 for 3 EXEC1 cycles -> ir_wen_o high only in the first EXEC1 cycle; mem_read_o high for 4 cycles; pc_wen_o on the 4th; EXEC2 then asserts regfile_wen_o for 1 cycle.
- Store with waitrequest_i=0 -> mem_write_o=1 and mem_read_o=0 for one EXEC1 cycle; regfile_wen_o=0.
- halt_req_i=1 together with muldiv_busy_i=1 for 5 cycles -> 5 STALL cycles, then HALTED; active_o=0 and state_o=5 held for 20 cycles.
- muldiv_busy_i stuck high, STALL_LIMIT=8 -> HALTED after 8 STALL cycles; fault_o=1.
- reset_i pulsed asynchronously mid-FETCH with waitrequest_i=1 -> strobes drop in the same cycle; state_o=0 after release; FETCH resumes one cycle later.
